game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
//  Top-level game sequencer for the 8x4 Tetris board. Owns the settled-board and falling-piece registers.
//  Spawns pieces and applies player moves and gravity. Locks landed pieces.
//  Drives the line-clear/redraw datapath through a req/ack handshake until no full row remains.
//  Board bit map: row r = bits[4r+3:4r]. Row 0 is the top, row 7 the bottom. Column c = bit (4r+c).
// PARAMETERS
//  GRAVITY_TICKS  16  clka cycles between gravity steps (>=2)
//  LINES_W        8   width of the saturating lines-cleared counter
// PORTS
//  clka          in   1   system clock, all state updates on posedge
//  restart_n     in   1   asynchronous active-low reset
//  start         in   1   1-cycle pulse: begin game from IDLE or OVER
//  btn_left      in   1   1-cycle pulse, already synchronised and edge-detected
//  btn_right     in   1   1-cycle pulse
//  btn_drop      in   1   1-cycle pulse (see CONFIGURATION)
//  piece_in      in   2   next piece code from the RNG: 00 single, 01 bar2, 10 square, 11 L
//  piece_req     out  1   1-cycle pulse when piece_in is consumed
//  dp_req        out  1   1-cycle pulse: dp_board_out is valid for a clear pass
//  dp_board_out  out  32  settled board presented to the clear datapath
//  dp_ack        in   1   1-cycle pulse: dp_board_in holds the cleared board
//  dp_board_in   in   32  board returned by the clear datapath
//  state         out  3   FSM state, encoding below (GEN=0 matches the datapath)
//  board_disp    out  32  settled | falling mask, for display
//  game_over     out  1   high while in OVER
//  lines         out  LINES_W  total rows cleared, saturating
// BEHAVIOUR
//  Reset (async, restart_n=0):
//   - state=IDLE; board, mask, gravity timer and lines =0.
//   - All output pulses =0; game_over=0.
//  States:
//   - IDLE=7: on start -> GEN.
//   - GEN=0: assert piece_req and load mask from spawn table: 00:{1} 01:{1,2} 10:{1,2,5,6} 11:{1,5,6}.
//     If spawn mask & board != 0 -> OVER. Otherwise -> PLAY and reset the gravity timer.
//   - PLAY=1: timer counts 0..GRAVITY_TICKS-1.
//     Move rules, one move per cycle:
//       left  = mask>>1; blocked if any mask bit is in column 0.
//       right = mask<<1; blocked if any mask bit is in column 3.
//       Either move is also blocked if the shifted mask & board != 0.
//       Blocked moves are ignored. left & right together: both ignored.
//     On timer wrap: fall = mask<<4. If mask[31:28]!=0 or fall & board !=0 -> LOCK. Otherwise mask<=fall.
//     Move and gravity in the same cycle: gravity is evaluated against the post-move mask next cycle; the timer holds at its wrap value.
//   - LOCK=2: board<=board|mask, mask<=0 -> CLEAR (1 cycle).
//   - CLEAR=3: if no row ==4'hF -> GEN. Otherwise pulse dp_req with dp_board_out=board -> WAIT.
//   - WAIT=4: on dp_ack:
//       lines += fullrows(board) - fullrows(dp_board_in), saturating at all-ones.
//       board<=dp_board_in -> CLEAR.
//     The loop repeats because the datapath clears at most 2 rows per pass.
//   - OVER=5: game_over=1; buttons and dp_ack are ignored.
//     On start: board, mask and lines <=0 -> GEN.
//  Handshake rules:
//   - dp_ack outside WAIT is ignored.
//   - dp_req never reasserts before dp_ack.
//   - No timeout.
//  start while in PLAY, LOCK, CLEAR or WAIT is ignored.
//  board_disp and dp_board_out are registered-state combinational; latency 0 from state.
// CONFIGURATION
//  GAME_CTRL_HARD_DROP_EN:
//   - Defined: btn_drop in PLAY sets a drop flag. While the flag is set, the mask falls one row per cycle (gravity timer bypassed, left/right ignored) until blocked -> LOCK. The flag clears in LOCK.
//   - Undefined: btn_drop is ignored; falls are driven by gravity only.
// STRUCTURE
//  tetris_pkg:
//   - state encodings ST_IDLE..ST_OVER
//   - piece codes and the SPAWN_MASK table
//   - ROWS=8, COLS=4, COL0_MASK=32'h11111111, COL3_MASK=32'h88888888
//   - functions row_full(board,r) and fullrows(board)
//  Sub-module game_piece_shift: combinational (mask, board, dir) -> (next_mask, blocked), shared by left/right/fall.
// TESTING
//  1. Reset then start, piece_in=10 -> piece_req 1 cycle; mask=32'h66; state=PLAY.
//  2. Piece 00 on empty board, GRAVITY_TICKS=4:
//     - After 7 falls, mask=32'h2000_0000 -> LOCK.
//     - board=32'h2000_0000, no dp_req, -> GEN.
//  3. board=32'hF000_0000, lock bit1:
//     - dp_req with dp_board_out=32'hF000_0002; return dp_board_in=32'h0000_0020.
//     - lines=1, then -> GEN.
//  4. Two full bottom rows plus a third full row at row 4:
//     - Two dp_req passes; lines=3.
//     - A dp_ack asserted during PLAY is ignored.
//  5. board bit5 set, piece_in=11 -> OVER, game_over=1. start -> board=0, lines=0, GEN.
//  6. Mask at column 0 with btn_left -> unchanged. restart_n low mid-WAIT -> IDLE, all outputs 0.
//     With GAME_CTRL_HARD_DROP_EN defined: btn_drop -> bottom reached in <=7 cycles.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared encodings, board geometry and row helpers for the 8x4 board game sequencer.
// Row r occupies bits [4r+3:4r]. Row 0 is the top row.
package tetris_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 4;
    localparam logic [31:0] COL0_MASK = 32'h1111_1111;
    localparam logic [31:0] COL3_MASK = 32'h8888_8888;

    typedef enum logic [2:0] {
        ST_GEN   = 3'd0,
        ST_PLAY  = 3'd1,
        ST_LOCK  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_WAIT  = 3'd4,
        ST_OVER  = 3'd5,
        ST_IDLE  = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        PC_SINGLE = 2'b00,
        PC_BAR2   = 2'b01,
        PC_SQUARE = 2'b10,
        PC_L      = 2'b11
    } piece_e;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2
    } dir_e;

    // Indexed by piece code: L, square, bar2, single.
    localparam logic [3:0][31:0] SPAWN_MASK = {32'h62, 32'h66, 32'h6, 32'h2};

    function automatic logic row_full(input logic [31:0] board, input int r);
        return &board[4*r +: 4];
    endfunction

    function automatic logic [3:0] fullrows(input logic [31:0] board);
        logic [3:0] n;
        n = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_full(board, r)) n = n + 4'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/game_piece_shift.sv
// Purpose: shift a piece mask one step left, right or down and flag edge or board collisions.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller discards the result when blocked.
module game_piece_shift
    import tetris_pkg::*;
(
    input  logic [31:0] mask,
    input  logic [31:0] board,
    input  logic [1:0]  dir,
    output logic [31:0] next_mask,
    output logic        blocked
);

    logic edge_hit;

    always_comb begin
        next_mask = mask << 4;
        edge_hit  = |mask[31:28];
        case (dir)
            DIR_LEFT: begin
                next_mask = mask >> 1;
                edge_hit  = |(mask & COL0_MASK);
            end
            DIR_RIGHT: begin
                next_mask = mask << 1;
                edge_hit  = |(mask & COL3_MASK);
            end
            default: begin
                next_mask = mask << 4;
                edge_hit  = |mask[31:28];
            end
        endcase
        blocked = edge_hit | (|(next_mask & board));
    end

endmodule

// File: rtl/game_ctrl.sv
// Purpose: game sequencer owning settled board and falling piece; spawn, move, gravity, lock, clear loop.
// Latency: state/board outputs are direct register views; piece_req and dp_req pulse one cycle after GEN/CLEAR.
// Backpressure: waits indefinitely in WAIT for dp_ack; GAME_CTRL_HARD_DROP_EN adds the hard-drop button.
module game_ctrl
    import tetris_pkg::*;
#(
    parameter int GRAVITY_TICKS = 16,
    parameter int LINES_W       = 8
) (
    input  logic               clka,
    input  logic               restart_n,
    input  logic               start,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_drop,
    input  logic [1:0]         piece_in,
    output logic               piece_req,
    output logic               dp_req,
    output logic [31:0]        dp_board_out,
    input  logic               dp_ack,
    input  logic [31:0]        dp_board_in,
    output logic [2:0]         state,
    output logic [31:0]        board_disp,
    output logic               game_over,
    output logic [LINES_W-1:0] lines
);

    localparam int TW = $clog2(GRAVITY_TICKS);
    localparam logic [TW-1:0] WRAP = TW'(GRAVITY_TICKS - 1);

    state_e             state_q, state_d;
    logic [31:0]        board_q, board_d;
    logic [31:0]        mask_q, mask_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [LINES_W-1:0] lines_q, lines_d;
    logic               piece_req_q, piece_req_d;
    logic               dp_req_q, dp_req_d;

    logic        drop_act;
    logic        move_try;
    logic [1:0]  shift_dir;
    logic [31:0] shift_mask;
    logic        shift_blk;
    logic [3:0]  rows_before, rows_after, rows_cleared;
    logic [LINES_W:0] lines_sum;

`ifdef GAME_CTRL_HARD_DROP_EN
    logic drop_q, drop_d;
    assign drop_act = drop_q;
`else
    logic unused_btn_drop;
    assign unused_btn_drop = btn_drop;
    assign drop_act = 1'b0;
`endif

    // Both buttons at once cancel; a hard drop overrides sideways moves.
    assign move_try  = btn_left ^ btn_right;
    assign shift_dir = (move_try && !drop_act) ? (btn_left ? DIR_LEFT : DIR_RIGHT) : DIR_DOWN;

    game_piece_shift u_shift (
        .mask      (mask_q),
        .board     (board_q),
        .dir       (shift_dir),
        .next_mask (shift_mask),
        .blocked   (shift_blk)
    );

    assign rows_before  = fullrows(board_q);
    assign rows_after   = fullrows(dp_board_in);
    assign rows_cleared = (rows_before > rows_after) ? rows_before - rows_after : 4'd0;
    assign lines_sum    = {1'b0, lines_q} + (LINES_W+1)'(rows_cleared);

    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        mask_d      = mask_q;
        timer_d     = timer_q;
        lines_d     = lines_q;
        piece_req_d = 1'b0;
        dp_req_d    = 1'b0;
`ifdef GAME_CTRL_HARD_DROP_EN
        drop_d      = drop_q;
`endif
        case (state_q)
            ST_IDLE: if (start) state_d = ST_GEN;
            ST_GEN: begin
                piece_req_d = 1'b1;
                mask_d      = SPAWN_MASK[piece_in];
                timer_d     = '0;
                state_d     = |(SPAWN_MASK[piece_in] & board_q) ? ST_OVER : ST_PLAY;
            end
            ST_PLAY: begin
`ifdef GAME_CTRL_HARD_DROP_EN
                if (btn_drop) drop_d = 1'b1;
`endif
                if (drop_act) begin
                    if (shift_blk) state_d = ST_LOCK;
                    else           mask_d  = shift_mask;
                end else if (move_try) begin
                    // A move at the wrap defers gravity to the next cycle.
                    if (!shift_blk) mask_d = shift_mask;
                    if (timer_q != WRAP) timer_d = timer_q + 1'b1;
                end else if (timer_q == WRAP) begin
                    timer_d = '0;
                    if (shift_blk) state_d = ST_LOCK;
                    else           mask_d  = shift_mask;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_LOCK: begin
                board_d = board_q | mask_q;
                mask_d  = '0;
                state_d = ST_CLEAR;
`ifdef GAME_CTRL_HARD_DROP_EN
                drop_d  = 1'b0;
`endif
            end
            ST_CLEAR: begin
                if (rows_before == 4'd0) begin
                    state_d = ST_GEN;
                end else begin
                    dp_req_d = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dp_ack) begin
                    lines_d = lines_sum[LINES_W] ? '1 : lines_sum[LINES_W-1:0];
                    board_d = dp_board_in;
                    state_d = ST_CLEAR;
                end
            end
            ST_OVER: begin
                if (start) begin
                    board_d = '0;
                    mask_d  = '0;
                    lines_d = '0;
                    state_d = ST_GEN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state_q     <= ST_IDLE;
            board_q     <= '0;
            mask_q      <= '0;
            timer_q     <= '0;
            lines_q     <= '0;
            piece_req_q <= 1'b0;
            dp_req_q    <= 1'b0;
`ifdef GAME_CTRL_HARD_DROP_EN
            drop_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            mask_q      <= mask_d;
            timer_q     <= timer_d;
            lines_q     <= lines_d;
            piece_req_q <= piece_req_d;
            dp_req_q    <= dp_req_d;
`ifdef GAME_CTRL_HARD_DROP_EN
            drop_q      <= drop_d;
`endif
        end
    end

    assign state        = state_q;
    assign board_disp   = board_q | mask_q;
    assign dp_board_out = board_q;
    assign game_over    = (state_q == ST_OVER);
    assign lines        = lines_q;
    assign piece_req    = piece_req_q;
    assign dp_req       = dp_req_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with GRAVITY_TICKS=4: move table plus multi-cycle spawn/lock/clear/over sequences.
module tb_game_ctrl;

    localparam logic [2:0] S_GEN = 3'd0, S_PLAY = 3'd1, S_LOCK = 3'd2, S_CLEAR = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4, S_OVER = 3'd5, S_IDLE = 3'd7;

    logic        clka = 1'b0;
    logic        restart_n = 1'b1;
    logic        start = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_drop = 1'b0;
    logic [1:0]  piece_in = 2'b00;
    logic        piece_req, dp_req, dp_ack = 1'b0, game_over;
    logic [31:0] dp_board_out, dp_board_in = 32'h0, board_disp;
    logic [2:0]  state;
    logic [7:0]  lines;

    int n_tests = 0;
    int n_fail = 0;
    int dp_req_cnt = 0;

    game_ctrl #(.GRAVITY_TICKS(4), .LINES_W(8)) dut (
        .clka(clka), .restart_n(restart_n), .start(start),
        .btn_left(btn_left), .btn_right(btn_right), .btn_drop(btn_drop),
        .piece_in(piece_in), .piece_req(piece_req),
        .dp_req(dp_req), .dp_board_out(dp_board_out),
        .dp_ack(dp_ack), .dp_board_in(dp_board_in),
        .state(state), .board_disp(board_disp),
        .game_over(game_over), .lines(lines)
    );

    always #5 clka = ~clka;

    always @(negedge clka) if (dp_req) dp_req_cnt++;

    typedef struct {
        logic        l;
        logic        r;
        logic [31:0] disp;
        logic [2:0]  st;
    } mv_t;
    mv_t tbl [14];

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int n = 0;
        while (state !== st && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(state), 32'(st));
    endtask

    task automatic do_reset();
        {start, btn_left, btn_right, btn_drop, dp_ack} = '0;
        restart_n = 1'b0;
        tick();
        restart_n = 1'b1;
        tick();
    endtask

    task automatic land(input int nl, input int nr);
        for (int i = 0; i < nl; i++) begin btn_left = 1'b1; tick(); btn_left = 1'b0; end
        for (int i = 0; i < nr; i++) begin btn_right = 1'b1; tick(); btn_right = 1'b0; end
        wait_state(S_LOCK, 64, "land_lock");
    endtask

    task automatic ack(input logic [31:0] b);
        dp_board_in = b;
        dp_ack = 1'b1;
        tick();
        dp_ack = 1'b0;
    endtask

    initial begin
        // Single piece at col1 row0, timer at 0 when the table starts.
        tbl[0]  = '{1'b1, 1'b0, 32'h0000_0001, S_PLAY};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_0001, S_PLAY};
        tbl[2]  = '{1'b1, 1'b1, 32'h0000_0001, S_PLAY};
        tbl[3]  = '{1'b0, 1'b0, 32'h0000_0010, S_PLAY};
        tbl[4]  = '{1'b0, 1'b1, 32'h0000_0020, S_PLAY};
        tbl[5]  = '{1'b0, 1'b1, 32'h0000_0040, S_PLAY};
        tbl[6]  = '{1'b0, 1'b1, 32'h0000_0080, S_PLAY};
        tbl[7]  = '{1'b0, 1'b0, 32'h0000_0800, S_PLAY};
        tbl[8]  = '{1'b0, 1'b1, 32'h0000_0800, S_PLAY};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_0400, S_PLAY};
        tbl[10] = '{1'b0, 1'b0, 32'h0000_0400, S_PLAY};
        tbl[11] = '{1'b1, 1'b0, 32'h0000_0200, S_PLAY};
        tbl[12] = '{1'b0, 1'b0, 32'h0000_2000, S_PLAY};
        tbl[13] = '{1'b0, 1'b1, 32'h0000_4000, S_PLAY};

        #2;
        restart_n = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_disp", board_disp, 32'h0);
        chk("rst_dp_board", dp_board_out, 32'h0);
        chk("rst_pulses", {30'h0, piece_req, dp_req}, 32'h0);
        chk("rst_over", 32'(game_over), 32'h0);
        chk("rst_lines", 32'(lines), 32'h0);
        restart_n = 1'b1;
        tick();

        // Square spawn.
        piece_in = 2'b10;
        start = 1'b1; tick(); start = 1'b0;
        chk("start_gen", 32'(state), 32'(S_GEN));
        tick();
        chk("sq_piece_req", 32'(piece_req), 32'h1);
        chk("sq_mask", board_disp, 32'h66);
        chk("sq_play", 32'(state), 32'(S_PLAY));
        tick();
        chk("sq_piece_req_off", 32'(piece_req), 32'h0);

        // Move table.
        do_reset();
        piece_in = 2'b00;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("mv_spawn", board_disp, 32'h2);
        for (int i = 0; i < 14; i++) begin
            btn_left = tbl[i].l;
            btn_right = tbl[i].r;
            tick();
            btn_left = 1'b0;
            btn_right = 1'b0;
            chk($sformatf("mv%0d_disp", i), board_disp, tbl[i].disp);
            chk($sformatf("mv%0d_state", i), 32'(state), 32'(tbl[i].st));
        end
        start = 1'b1; tick(); start = 1'b0;
        chk("start_in_play", 32'(state), 32'(S_PLAY));
        chk("start_in_play_disp", board_disp, 32'h4000);

        // Gravity only: 7 falls then lock, no clear pass.
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        begin
            int n = 0;
            while (state !== S_LOCK && n < 100) begin tick(); n++; end
            chk("grav_cycles", 32'(n), 32'd32);
        end
        chk("grav_bottom", board_disp, 32'h2000_0000);
        tick();
        chk("grav_clear", 32'(state), 32'(S_CLEAR));
        chk("grav_board", dp_board_out, 32'h2000_0000);
        tick();
        chk("grav_gen", 32'(state), 32'(S_GEN));
        tick();
        chk("grav_respawn", board_disp, 32'h2000_0002);
        chk("grav_no_dp", 32'(dp_req_cnt), 32'd0);

        // Fill the bottom row: one clear pass, lines=1.
        land(1, 0); wait_state(S_PLAY, 8, "fill_play0");
        land(0, 1); wait_state(S_PLAY, 8, "fill_play1");
        land(0, 2); wait_state(S_WAIT, 8, "fill_wait");
        chk("c1_dp_req", 32'(dp_req), 32'h1);
        chk("c1_dp_board", dp_board_out, 32'hF000_0000);
        piece_in = 2'b10;
        tick();
        chk("c1_dp_req_off", 32'(dp_req), 32'h0);
        ack(32'h9900_0000);
        chk("c1_state", 32'(state), 32'(S_CLEAR));
        chk("c1_lines", 32'(lines), 32'd1);
        tick();
        chk("c1_gen", 32'(state), 32'(S_GEN));
        tick();
        chk("c1_square", board_disp, 32'h9900_0066);

        // dp_ack in PLAY is ignored; square completes two rows, two passes.
        ack(32'hFFFF_FFFF);
        chk("play_ack_disp", board_disp, 32'h9900_0066);
        chk("play_ack_lines", 32'(lines), 32'd1);
        wait_state(S_LOCK, 64, "sq_lock");
        wait_state(S_WAIT, 8, "c2_wait");
        chk("c2_dp_board", dp_board_out, 32'hFF00_0000);
        tick(); tick(); tick();
        chk("c2_hold", 32'(state), 32'(S_WAIT));
        chk("c2_no_repeat", 32'(dp_req_cnt), 32'd2);
        ack(32'hF000_0000);
        chk("c2_lines", 32'(lines), 32'd2);
        wait_state(S_WAIT, 4, "c3_wait");
        chk("c3_dp_board", dp_board_out, 32'hF000_0000);
        piece_in = 2'b11;
        ack(32'h0000_0020);
        chk("c3_lines", 32'(lines), 32'd3);
        tick();
        tick();
        chk("over_state", 32'(state), 32'(S_OVER));
        chk("over_flag", 32'(game_over), 32'h1);
        chk("over_disp", board_disp, 32'h62);
        chk("dp_req_total", 32'(dp_req_cnt), 32'd3);

        // OVER ignores buttons and dp_ack; start wipes the game.
        btn_left = 1'b1;
        ack(32'hFFFF_FFFF);
        btn_left = 1'b0;
        chk("over_ign_state", 32'(state), 32'(S_OVER));
        chk("over_ign_disp", board_disp, 32'h62);
        chk("over_ign_lines", 32'(lines), 32'd3);
        piece_in = 2'b00;
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_gen", 32'(state), 32'(S_GEN));
        chk("restart_disp", board_disp, 32'h0);
        chk("restart_lines", 32'(lines), 32'd0);
        chk("restart_over", 32'(game_over), 32'h0);
        tick();

        // Drop button: seven cycles later the piece is at the bottom only with hard drop built in.
        btn_drop = 1'b1; tick(); btn_drop = 1'b0;
        for (int i = 0; i < 7; i++) tick();
`ifdef GAME_CTRL_HARD_DROP_EN
        chk("drop_bottom", board_disp, 32'h2000_0000);
`else
        chk("drop_ignored", board_disp, 32'h0000_0200);
`endif
        wait_state(S_LOCK, 64, "drop_lock");
        wait_state(S_PLAY, 8, "refill_play0");
        land(1, 0); wait_state(S_PLAY, 8, "refill_play1");
        land(0, 1); wait_state(S_PLAY, 8, "refill_play2");
        land(0, 2); wait_state(S_WAIT, 8, "refill_wait");
        chk("refill_dp_board", dp_board_out, 32'hF000_0000);

        // Asynchronous reset in the middle of WAIT.
        #2;
        restart_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'(S_IDLE));
        chk("arst_disp", board_disp, 32'h0);
        chk("arst_dp_board", dp_board_out, 32'h0);
        chk("arst_pulses", {30'h0, piece_req, dp_req}, 32'h0);
        chk("arst_over_lines", {23'h0, game_over, lines}, 32'h0);
        tick();
        restart_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
